alu_arbiter: RTL and testbench
==============================

Name: alu_arbiter

Overview:
- Shares one registered ALU (3-bit operands a/b, 4-bit opcode, 6-bit result) between NUM_REQ requesters.
- Each requester presents an operation through a valid/ready handshake.
- The block round-robin arbitrates, drives the ALU inputs, waits ALU_LAT cycles and returns the result, tagged with the requester id, on a valid/ready response channel.
- Sits between the requester logic and the alu instance; it is the only driver of the ALU inputs.

Parameters:
- NUM_REQ, 4: number of requesters, 2..8.
- DATA_W, 3: operand width.
- OP_W, 4: opcode width.
- RES_W, 6: ALU result width.
- ALU_LAT, 1: ALU input-to-result latency in clk cycles, ≥1.
- ID_W, 2: requester id width, equal to clog2(NUM_REQ).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  per-requester operation valid.
- req_ready  out  NUM_REQ  per-requester accept, one-hot or zero.
- req_a  in  NUM_REQ*DATA_W  packed operand a; requester i occupies slice i.
- req_b  in  NUM_REQ*DATA_W  packed operand b.
- req_op  in  NUM_REQ*OP_W  packed opcode.
- alu_a  out  DATA_W  to ALU a.
- alu_b  out  DATA_W  to ALU b.
- alu_opcode  out  OP_W  to ALU opcode.
- alu_result  in  RES_W  from ALU result.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response accept.
- rsp_id  out  ID_W  id of the requester that owns the response.
- rsp_result  out  RES_W  captured ALU result.

Behaviour:
- Reset (rst_n=0, takes effect immediately):
  - state=IDLE, last_grant=NUM_REQ-1, so requester 0 has first priority.
  - wait counter=0.
  - alu_a, alu_b, alu_opcode, rsp_valid, rsp_id, rsp_result all 0.
  - req_ready=0.
- State IDLE:
  - Winner = first i with req_valid[i]=1, searching last_grant+1, last_grant+2, … modulo NUM_REQ.
  - req_ready is combinational: one-hot at the winner, 0 when no req_valid is high. A handshake therefore occurs in the same cycle.
  - On the handshake edge: load alu_a, alu_b, alu_opcode from the winner's slices; latch id; set last_grant=winner; go to ISSUE.
- State ISSUE (1 cycle): ALU inputs are stable; the ALU samples them at the end of the cycle. Load counter=ALU_LAT-1; go to WAIT.
- State WAIT (ALU_LAT cycles):
  - Decrement the counter each cycle.
  - When the counter is 0: capture alu_result into rsp_result, set rsp_id, set rsp_valid=1, go to RESP.
- State RESP:
  - rsp_valid=1; rsp_id and rsp_result are held stable until rsp_ready=1.
  - On the handshake edge: rsp_valid=0, go to IDLE.
  - req_ready=0 throughout RESP, ISSUE and WAIT.
- Latency and throughput:
  - Request handshake at cycle c gives rsp_valid at cycle c+ALU_LAT+2.
  - With rsp_ready tied high, at most one operation per ALU_LAT+3 cycles.
- ALU inputs hold their last values after an operation; they are not cleared.
- Requester rules:
  - Operands must be stable while req_valid=1.
  - Dropping req_valid before grant is legal and simply removes the request from arbitration.
- Boundary cases:
  - No requests: stay in IDLE; req_ready=0.
  - Only one requester active: it is granted on every IDLE visit.
  - Winner's req_valid falls in the same cycle as the grant: no handshake, stay in IDLE, last_grant unchanged.
  - rsp_ready already high on RESP entry: RESP lasts 1 cycle.
  - Reset mid-operation: the operation is abandoned and no response is produced.
  - last_grant wraps from NUM_REQ-1 to 0.

Optional Feature:
- Macro: ALU_ARB_STATS_EN.
- When defined:
  - Adds output op_count[15:0], reset to 0.
  - Increments on each response handshake and saturates at 16'hFFFF.
  - Adds output busy (state != IDLE).
- When undefined: neither port nor its logic exists; behaviour is otherwise identical.

Decomposition:
- Package alu_arb_pkg:
  - State encoding constants IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2, RESP=2'd3.
  - Default widths DATA_W, OP_W and RES_W.
- Sub-module rr_arbiter:
  - Combinational.
  - Inputs: req vector and last_grant.
  - Outputs: one-hot grant, encoded grant id and any-grant flag.
  - The top owns all state, including last_grant.

Test Plan:
- Bench uses a registered ALU stub, ALU_LAT=1, where opcode 0000 gives a+b.
- Single request: after reset, req_valid[0]=1 with a=5, b=6, op=0000 at cycle 0.
  - req_ready[0]=1 in cycle 0.
  - alu_a=5, alu_b=6 in cycle 1.
  - rsp_valid=1, rsp_id=0, rsp_result=11 in cycle 3.
- All four requesters valid from reset, each holding until its grant: grants occur in order 0,1,2,3, and each rsp_id matches the originating operands.
- req0 and req2 held valid continuously with rsp_ready=1: grant sequence is 0,2,0,2, with each grant exactly 4 cycles apart.
- rsp_ready held low for 5 cycles in RESP:
  - rsp_valid, rsp_id and rsp_result stay stable and req_ready stays 0.
  - Next grant occurs in the first IDLE cycle after the handshake.
- rst_n pulsed low during WAIT:
  - All outputs are 0 immediately and no response appears.
  - After release, with req1 and req0 both valid, req0 is granted first.
- With ALU_ARB_STATS_EN defined: op_count = 3 after 3 completed operations; busy=1 from ISSUE through RESP.

Source files
------------

// File: rtl/alu_arb_pkg.sv
// Shared definitions for the ALU arbiter slice.
// - arb_state_e : arbiter FSM state encoding (Idle=0, Issue=1, Wait=2, Resp=3)
// - DefDataW / DefOpW / DefResW : default operand, opcode and result widths
package alu_arb_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StWait  = 2'd2,
    StResp  = 2'd3
  } arb_state_e;

  localparam int unsigned DefDataW = 3;
  localparam int unsigned DefOpW   = 4;
  localparam int unsigned DefResW  = 6;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter. Searches last_grant+1, last_grant+2, ... modulo NUM_REQ
// and picks the first active request. Holds no state; the caller owns last_grant.
// Ports:
//   req        in  NUM_REQ  request vector
//   last_grant in  ID_W     index of the previous winner
//   grant      out NUM_REQ  one-hot winner, zero when no request
//   grant_id   out ID_W     encoded winner
//   any_grant  out 1        at least one request is active
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    last_grant,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_id,
  output logic               any_grant
);

  always_comb begin
    logic [ID_W-1:0] sel;
    grant     = '0;
    grant_id  = '0;
    any_grant = 1'b0;
    sel       = '0;
    // i runs 1..NUM_REQ so the previous winner is visited last.
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      sel = ID_W'((32'(last_grant) + i) % NUM_REQ);
      if (!any_grant && req[sel]) begin
        grant[sel] = 1'b1;
        grant_id   = sel;
        any_grant  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one registered ALU between NUM_REQ requesters. Round-robin arbitrates operation
// requests (valid/ready), drives the ALU inputs, waits ALU_LAT cycles and returns the result
// tagged with the requester id on a valid/ready response channel.
// Optional feature (macro ALU_ARB_STATS_EN): adds op_count (saturating count of response
// handshakes) and busy (FSM not idle).
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   req_valid/req_ready   per-requester handshake (ready is combinational, one-hot or zero)
//   req_a/req_b/req_op    packed per-requester operands and opcode (requester i in slice i)
//   alu_a/alu_b/alu_opcode registered ALU inputs; hold their value after an operation
//   alu_result            ALU output
//   rsp_valid/rsp_ready   response handshake; rsp_id/rsp_result held while valid
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = DefDataW,
  parameter int unsigned OP_W    = DefOpW,
  parameter int unsigned RES_W   = DefResW,
  parameter int unsigned ALU_LAT = 1,
  parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_a,
  input  logic [NUM_REQ*DATA_W-1:0] req_b,
  input  logic [NUM_REQ*OP_W-1:0]   req_op,
  output logic [DATA_W-1:0]         alu_a,
  output logic [DATA_W-1:0]         alu_b,
  output logic [OP_W-1:0]           alu_opcode,
  input  logic [RES_W-1:0]          alu_result,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [ID_W-1:0]           rsp_id,
  output logic [RES_W-1:0]          rsp_result
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [15:0]               op_count,
  output logic                      busy
`endif
);

  localparam int unsigned CntW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

  arb_state_e          state_q, state_d;
  logic [ID_W-1:0]     last_grant_q, last_grant_d;
  logic [ID_W-1:0]     id_q, id_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0]   alu_a_d, alu_b_d;
  logic [OP_W-1:0]     alu_opcode_d;
  logic                rsp_valid_d;
  logic [ID_W-1:0]     rsp_id_d;
  logic [RES_W-1:0]    rsp_result_d;

  logic [NUM_REQ-1:0]  grant;
  logic [ID_W-1:0]     grant_id;
  logic                any_grant;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr_arbiter (
    .req        (req_valid),
    .last_grant (last_grant_q),
    .grant      (grant),
    .grant_id   (grant_id),
    .any_grant  (any_grant)
  );

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    id_d         = id_q;
    cnt_d        = cnt_q;
    alu_a_d      = alu_a;
    alu_b_d      = alu_b;
    alu_opcode_d = alu_opcode;
    rsp_valid_d  = rsp_valid;
    rsp_id_d     = rsp_id;
    rsp_result_d = rsp_result;
    req_ready    = '0;
    unique case (state_q)
      StIdle: begin
        // Gated by rst_n so no requester sees an accept while reset is held.
        if (rst_n) req_ready = grant;
        if (any_grant) begin
          alu_a_d      = req_a[32'(grant_id)*DATA_W +: DATA_W];
          alu_b_d      = req_b[32'(grant_id)*DATA_W +: DATA_W];
          alu_opcode_d = req_op[32'(grant_id)*OP_W +: OP_W];
          id_d         = grant_id;
          last_grant_d = grant_id;
          state_d      = StIssue;
        end
      end
      StIssue: begin
        cnt_d   = CntW'(ALU_LAT - 1);
        state_d = StWait;
      end
      StWait: begin
        if (cnt_q == '0) begin
          rsp_result_d = alu_result;
          rsp_id_d     = id_q;
          rsp_valid_d  = 1'b1;
          state_d      = StResp;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StResp: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      last_grant_q <= ID_W'(NUM_REQ - 1);
      id_q         <= '0;
      cnt_q        <= '0;
      alu_a        <= '0;
      alu_b        <= '0;
      alu_opcode   <= '0;
      rsp_valid    <= 1'b0;
      rsp_id       <= '0;
      rsp_result   <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      id_q         <= id_d;
      cnt_q        <= cnt_d;
      alu_a        <= alu_a_d;
      alu_b        <= alu_b_d;
      alu_opcode   <= alu_opcode_d;
      rsp_valid    <= rsp_valid_d;
      rsp_id       <= rsp_id_d;
      rsp_result   <= rsp_result_d;
    end
  end

`ifdef ALU_ARB_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_count <= '0;
    end else if (state_q == StResp && rsp_ready && op_count != 16'hFFFF) begin
      op_count <= op_count + 16'd1;
    end
  end

  assign busy = (state_q != StIdle);
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter (NUM_REQ=4, ALU_LAT=1) with a registered ALU stub.
// Expected responses are queued when requests are driven and popped on each response handshake.
module tb_alu_arbiter;

  localparam int NR = 4;
  localparam int DW = 3;
  localparam int OW = 4;
  localparam int RW = 6;
  localparam int IW = 2;

  logic           clk;
  logic           rst_n;
  logic [NR-1:0]  req_valid;
  logic [NR-1:0]  req_ready;
  logic [NR*DW-1:0] req_a;
  logic [NR*DW-1:0] req_b;
  logic [NR*OW-1:0] req_op;
  logic [DW-1:0]  alu_a;
  logic [DW-1:0]  alu_b;
  logic [OW-1:0]  alu_opcode;
  logic [RW-1:0]  alu_result;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [IW-1:0]  rsp_id;
  logic [RW-1:0]  rsp_result;
`ifdef ALU_ARB_STATS_EN
  logic [15:0]    op_count;
  logic           busy;
`endif

  typedef struct packed {
    logic [IW-1:0] id;
    logic [RW-1:0] res;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc   = 0;

  alu_arbiter #(
    .NUM_REQ (NR),
    .DATA_W  (DW),
    .OP_W    (OW),
    .RES_W   (RW),
    .ALU_LAT (1),
    .ID_W    (IW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_op     (req_op),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_opcode (alu_opcode),
    .alu_result (alu_result),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result)
`ifdef ALU_ARB_STATS_EN
    ,
    .op_count   (op_count),
    .busy       (busy)
`endif
  );

  // ALU stub behaviour: 0 add, 1 subtract, 2 and, others xor.
  function automatic logic [RW-1:0] alu_model(input logic [OW-1:0] op, input logic [DW-1:0] a,
                                              input logic [DW-1:0] b);
    case (op)
      4'd0:    return RW'(a) + RW'(b);
      4'd1:    return RW'(a) - RW'(b);
      4'd2:    return RW'(a & b);
      default: return RW'(a ^ b);
    endcase
  endfunction

  always @(posedge clk) alu_result <= alu_model(alu_opcode, alu_a, alu_b);

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Scoreboard: every response handshake must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      check("rsp_pending", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        exp_t e;
        e = exp_q.pop_front();
        check("rsp_id", 32'(rsp_id), 32'(e.id));
        check("rsp_result", 32'(rsp_result), 32'(e.res));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [DW-1:0] a, input logic [DW-1:0] b,
                        input logic [OW-1:0] op);
    req_a[i*DW +: DW]  = a;
    req_b[i*DW +: DW]  = b;
    req_op[i*OW +: OW] = op;
    req_valid[i]       = 1'b1;
  endtask

  task automatic exp_push(input int i);
    exp_t e;
    e.id  = IW'(i);
    e.res = alu_model(req_op[i*OW +: OW], req_a[i*DW +: DW], req_b[i*DW +: DW]);
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b0;
    req_a     = '0;
    req_b     = '0;
    req_op    = '0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Waits (bounded) for a request handshake; returns at the negedge before the handshake edge.
  task automatic wait_grant(input string tag, output int id, output int at_cyc);
    bit ok = 1'b0;
    id = 0;
    at_cyc = 0;
    for (int k = 0; k < 20 && !ok; k++) begin
      @(negedge clk);
      if (|(req_valid & req_ready)) begin
        ok = 1'b1;
        at_cyc = cyc;
        for (int j = 0; j < NR; j++) if (req_ready[j]) id = j;
      end
    end
    check({tag, "_seen"}, 32'(ok), 32'd1);
  endtask

  task automatic drain(input string tag);
    for (int k = 0; k < 40 && exp_q.size() != 0; k++) @(negedge clk);
    check({tag, "_drain"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int id, c0, c1;
    rst_n = 1'b0;
    req_valid = '0; rsp_ready = 1'b0; req_a = '0; req_b = '0; req_op = '0;
    #1;
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_alu", {alu_a, alu_b, alu_opcode}, 32'd0);
    check("rst_rsp", {rsp_valid, rsp_id, rsp_result}, 32'd0);

    // Single request: grant in cycle 0, ALU inputs in cycle 1, response in cycle 3.
    do_reset();
    set_op(0, 3'd5, 3'd6, 4'd0);
    exp_push(0);
    rsp_ready = 1'b1;
    @(negedge clk);
    check("s_ready_c0", 32'(req_ready), 32'h1);
`ifdef ALU_ARB_STATS_EN
    check("s_busy_c0", 32'(busy), 32'd0);
`endif
    step();
    req_valid = '0;
    @(negedge clk);
    check("s_alu_c1", {alu_a, alu_b}, {26'd0, 3'd5, 3'd6});
    check("s_ready_c1", 32'(req_ready), 32'd0);
    step();
    @(negedge clk);
    check("s_valid_c2", 32'(rsp_valid), 32'd0);
    step();
    @(negedge clk);
    check("s_rsp_c3", {rsp_valid, rsp_id, rsp_result}, {23'd0, 1'b1, 2'd0, 6'd11});
`ifdef ALU_ARB_STATS_EN
    check("s_busy_c3", 32'(busy), 32'd1);
`endif
    step();
    @(negedge clk);
    check("s_idle_c4", 32'(rsp_valid), 32'd0);
`ifdef ALU_ARB_STATS_EN
    check("s_count", 32'(op_count), 32'd1);
    check("s_busy_c4", 32'(busy), 32'd0);
`endif
    drain("s");

    // No requests: stays idle with no accept.
    repeat (3) begin
      @(negedge clk);
      check("idle_ready", 32'(req_ready), 32'd0);
    end

    // All four valid from reset: grants 0,1,2,3.
    do_reset();
    rsp_ready = 1'b1;
    for (int i = 0; i < NR; i++) set_op(i, DW'(i + 1), DW'(7 - i), OW'(i));
    for (int i = 0; i < NR; i++) exp_push(i);
    for (int k = 0; k < NR; k++) begin
      wait_grant("all", id, c0);
      check("all_order", 32'(id), 32'(k));
      step();
      req_valid[id] = 1'b0;
    end
    drain("all");
`ifdef ALU_ARB_STATS_EN
    check("all_count", 32'(op_count), 32'd4);
`endif

    // req0 and req2 held continuously: 0,2,0,2 exactly 4 cycles apart.
    do_reset();
    rsp_ready = 1'b1;
    set_op(0, 3'd7, 3'd7, 4'd0);
    set_op(2, 3'd6, 3'd1, 4'd1);
    exp_push(0); exp_push(2); exp_push(0); exp_push(2);
    c1 = 0;
    for (int k = 0; k < 4; k++) begin
      wait_grant("rr", id, c0);
      check("rr_order", 32'(id), (k % 2 == 0) ? 32'd0 : 32'd2);
      if (k > 0) check("rr_spacing", 32'(c0 - c1), 32'd4);
      c1 = c0;
      step();
    end
    req_valid = '0;
    drain("rr");

    // Response back-pressure for 5 cycles, then next grant in the first idle cycle.
    do_reset();
    set_op(1, 3'd3, 3'd2, 4'd0);
    set_op(3, 3'd4, 3'd6, 4'd3);
    exp_push(1); exp_push(3);
    wait_grant("bp", id, c0);
    check("bp_first", 32'(id), 32'd1);
    step();
    req_valid[1] = 1'b0;
    step(); step();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_hold", {rsp_valid, rsp_id, rsp_result}, {23'd0, 1'b1, 2'd1, 6'd5});
      check("bp_ready", 32'(req_ready), 32'd0);
      step();
    end
    rsp_ready = 1'b1;
    step();
    @(negedge clk);
    check("bp_next_grant", 32'(req_ready), 32'h8);
    step();
    req_valid[3] = 1'b0;
    drain("bp");

    // Reset during WAIT: abandoned, all outputs cleared at once; req0 wins after release.
    do_reset();
    rsp_ready = 1'b1;
    set_op(2, 3'd1, 3'd1, 4'd0);
    wait_grant("mr", id, c0);
    step();
    req_valid = '0;
    step();
    rst_n = 1'b0;
    #1;
    check("mr_alu", {alu_a, alu_b, alu_opcode}, 32'd0);
    check("mr_rsp", {rsp_valid, rsp_id, rsp_result}, 32'd0);
    set_op(1, 3'd2, 3'd2, 4'd2);
    set_op(0, 3'd5, 3'd3, 4'd3);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("mr_hold_ready", 32'(req_ready), 32'd0);
      check("mr_hold_valid", 32'(rsp_valid), 32'd0);
    end
    exp_push(0); exp_push(1);
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 2; k++) begin
      wait_grant("mr", id, c0);
      check("mr_order", 32'(id), 32'(k));
      step();
      req_valid[id] = 1'b0;
    end
    drain("mr");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish (observed timeout, required finish)");
    $fatal(1);
  end

endmodule
